// File: rtl/ten_gig_link_ctrl.sv
// 10GBASE-R link bring-up controller.
// Sequences the PCS/PMA reset, waits for reset-done, block lock and receive
// link, requires a stable window before declaring the link up, and gates the
// XGMII transmit stream to idles whenever the link is not up.
// Optional feature: define LINK_CTRL_STAT_EN to enable the link-drop counter;
// otherwise o_link_drop_cnt is tied to zero.
module ten_gig_link_ctrl #(
  parameter int unsigned P_RST_CYCLES = 16,
  parameter int unsigned P_TIMEOUT    = 1000000,
  parameter int unsigned P_STABLE     = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_soft_rst,
  input  logic        i_rst_done,
  input  logic        i_block_sync,
  input  logic        i_pcs_rx_link,
  input  logic [63:0] i_xgmii_txd,
  input  logic [7:0]  i_xgmii_txc,
  output logic [63:0] o_xgmii_txd,
  output logic [7:0]  o_xgmii_txc,
  output logic        o_pcs_rst,
  output logic        o_link_up,
  output logic [7:0]  o_retry_cnt,
  output logic [15:0] o_link_drop_cnt
);

  localparam logic [63:0] IdleTxd = 64'h0707070707070707;
  localparam logic [7:0]  IdleTxc = 8'hFF;

  // One shared cycle counter serves the reset hold, both timeouts and the
  // stable window; it is sized for the largest of the three.
  localparam int unsigned MaxRt  = (P_RST_CYCLES > P_TIMEOUT) ? P_RST_CYCLES : P_TIMEOUT;
  localparam int unsigned CntMax = (MaxRt > P_STABLE) ? MaxRt : P_STABLE;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] CntOne     = CntW'(1);
  localparam logic [CntW-1:0] RstLast    = CntW'(P_RST_CYCLES - 1);
  localparam logic [CntW-1:0] ToLast     = CntW'(P_TIMEOUT - 1);
  localparam logic [CntW-1:0] StableLast = CntW'(P_STABLE - 1);

  typedef enum logic [2:0] {
    StReset,
    StWaitDone,
    StWaitSync,
    StStable,
    StUp
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      retry_q, retry_d;
  logic            link_up_q, link_up_d;
  logic [63:0]     txd_q, txd_d;
  logic [7:0]      txc_q, txc_d;

  // Status synchronizers: bit 2 rst_done, bit 1 block_sync, bit 0 pcs_rx_link.
  logic [2:0] meta_q, meta_d;
  logic [2:0] sync_q, sync_d;

  logic rst_done_s;
  logic link_good_s;
  logic timeout;

  assign rst_done_s  = sync_q[2];
  assign link_good_s = sync_q[1] & sync_q[0];

  // Next value of the two synchronizer stages.
  always_comb begin
    meta_d = {i_rst_done, i_block_sync, i_pcs_rx_link};
    sync_d = meta_q;
  end

  // Bring-up FSM next state; a soft reset overrides everything, including a
  // coincident timeout, so it never counts as a retry.
  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    unique case (state_q)
      StReset: begin
        if (cnt_q == RstLast) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (rst_done_s) begin
          state_d = StWaitSync;
        end else if (cnt_q == ToLast) begin
          state_d = StReset;
          timeout = 1'b1;
        end
      end
      StWaitSync: begin
        if (!rst_done_s) begin
          state_d = StReset;
        end else if (link_good_s) begin
          state_d = StStable;
        end else if (cnt_q == ToLast) begin
          state_d = StReset;
          timeout = 1'b1;
        end
      end
      StStable: begin
        if (!rst_done_s) begin
          state_d = StReset;
        end else if (!link_good_s) begin
          state_d = StWaitSync;
        end else if (cnt_q == StableLast) begin
          state_d = StUp;
        end
      end
      StUp: begin
        if (!rst_done_s) begin
          state_d = StReset;
        end else if (!link_good_s) begin
          state_d = StWaitSync;
        end
      end
      default: state_d = StReset;
    endcase
    if (i_soft_rst) begin
      state_d = StReset;
      timeout = 1'b0;
    end
  end

  // Cycle counter: cleared on every state entry (and on soft reset, which
  // restarts the RESET hold); it is not needed while UP so it holds there.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || i_soft_rst) begin
      cnt_d = '0;
    end else if (state_q != StUp) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  // Retry counter saturates rather than wrapping.
  always_comb begin
    retry_d = retry_q;
    if (timeout && (retry_q != 8'hFF)) retry_d = retry_q + 8'd1;
  end

  // Registered outputs: link_up follows the next state so it is high exactly
  // while the state register holds UP; the data gate uses the current state,
  // giving one cycle of latency through the gate.
  always_comb begin
    link_up_d = (state_d == StUp);
    if (state_q == StUp) begin
      txd_d = i_xgmii_txd;
      txc_d = i_xgmii_txc;
    end else begin
      txd_d = IdleTxd;
      txc_d = IdleTxc;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= StReset;
      cnt_q     <= '0;
      retry_q   <= '0;
      meta_q    <= '0;
      sync_q    <= '0;
      link_up_q <= 1'b0;
      txd_q     <= IdleTxd;
      txc_q     <= IdleTxc;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      link_up_q <= link_up_d;
      txd_q     <= txd_d;
      txc_q     <= txc_d;
    end
  end

`ifdef LINK_CTRL_STAT_EN
  logic [15:0] drop_q, drop_d;

  // Count UP exits caused by status loss; soft-reset exits are not link drops.
  always_comb begin
    drop_d = drop_q;
    if ((state_q == StUp) && (state_d != StUp) && !i_soft_rst && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  // Link-drop counter register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign o_link_drop_cnt = drop_q;
`else
  assign o_link_drop_cnt = '0;
`endif

  // PCS reset is decoded straight from the state register so it is asserted
  // as soon as the asynchronous reset forces RESET.
  assign o_pcs_rst   = (state_q == StReset);
  assign o_link_up   = link_up_q;
  assign o_xgmii_txd = txd_q;
  assign o_xgmii_txc = txc_q;
  assign o_retry_cnt = retry_q;

endmodule

// File: tb/tb_ten_gig_link_ctrl.sv
// Self-checking bench for ten_gig_link_ctrl (P_RST_CYCLES=4, P_TIMEOUT=100,
// P_STABLE=8). Inputs are driven on the falling edge, outputs sampled on the
// falling edge. Honours LINK_CTRL_STAT_EN for the drop-counter expectation.
`timescale 1ns/1ps
module tb_ten_gig_link_ctrl;

  localparam logic [63:0] IdleD = 64'h0707070707070707;
  localparam logic [7:0]  IdleC = 8'hFF;

  logic        i_clk;
  logic        i_rst;
  logic        i_soft_rst;
  logic        i_rst_done;
  logic        i_block_sync;
  logic        i_pcs_rx_link;
  logic [63:0] i_xgmii_txd;
  logic [7:0]  i_xgmii_txc;
  logic [63:0] o_xgmii_txd;
  logic [7:0]  o_xgmii_txc;
  logic        o_pcs_rst;
  logic        o_link_up;
  logic [7:0]  o_retry_cnt;
  logic [15:0] o_link_drop_cnt;

  ten_gig_link_ctrl #(
    .P_RST_CYCLES(4),
    .P_TIMEOUT   (100),
    .P_STABLE    (8)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_soft_rst     (i_soft_rst),
    .i_rst_done     (i_rst_done),
    .i_block_sync   (i_block_sync),
    .i_pcs_rx_link  (i_pcs_rx_link),
    .i_xgmii_txd    (i_xgmii_txd),
    .i_xgmii_txc    (i_xgmii_txc),
    .o_xgmii_txd    (o_xgmii_txd),
    .o_xgmii_txc    (o_xgmii_txc),
    .o_pcs_rst      (o_pcs_rst),
    .o_link_up      (o_link_up),
    .o_retry_cnt    (o_retry_cnt),
    .o_link_drop_cnt(o_link_drop_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_drop = 0;

  typedef struct {
    logic [63:0] txd;
    logic [7:0]  txc;
    logic        up;
    logic [63:0] exp_txd;
    logic [7:0]  exp_txc;
  } vec_t;

  typedef struct {
    logic [63:0] txd;
    logic [7:0]  txc;
  } exp_t;

  vec_t vecs[12];
  exp_t sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Applies the table entries of one phase; expected output is queued when
  // the vector is driven and compared one clock later.
  task automatic run_vectors(input logic up_phase);
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].up == up_phase) begin
        i_xgmii_txd = vecs[i].txd;
        i_xgmii_txc = vecs[i].txc;
        sb_q.push_back('{vecs[i].exp_txd, vecs[i].exp_txc});
        @(negedge i_clk);
        e = sb_q.pop_front();
        check($sformatf("vec%0d txd", i), o_xgmii_txd, e.txd);
        check($sformatf("vec%0d txc", i), {56'h0, o_xgmii_txc}, {56'h0, e.txc});
      end
    end
  endtask

  task automatic wait_up(input string name, input int budget);
    int c = 0;
    while (!o_link_up && c < budget) begin
      @(negedge i_clk);
      c++;
    end
    check(name, {63'h0, o_link_up}, 64'h1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " pcs_rst"}, {63'h0, o_pcs_rst}, 64'h1);
    check({tag, " link_up"}, {63'h0, o_link_up}, 64'h0);
    check({tag, " txd"}, o_xgmii_txd, IdleD);
    check({tag, " txc"}, {56'h0, o_xgmii_txc}, {56'h0, IdleC});
    check({tag, " retry"}, {56'h0, o_retry_cnt}, 64'h0);
    check({tag, " drop"}, {48'h0, o_link_drop_cnt}, 64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int rises;
    int width;
    logic prev;
    logic seen_up;
    logic dec;
    logic [7:0] prev_retry;

    vecs[0]  = '{64'hDEADBEEF01234567, 8'h00, 1'b1, 64'hDEADBEEF01234567, 8'h00};
    vecs[1]  = '{64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b1, 64'hFFFFFFFFFFFFFFFF, 8'hFF};
    vecs[2]  = '{64'h0000000000000000, 8'h00, 1'b1, 64'h0000000000000000, 8'h00};
    vecs[3]  = '{64'hD5555555555555FB, 8'h01, 1'b1, 64'hD5555555555555FB, 8'h01};
    vecs[4]  = '{64'h0123456789ABCDEF, 8'h00, 1'b1, 64'h0123456789ABCDEF, 8'h00};
    vecs[5]  = '{64'h07070707070707FD, 8'hFF, 1'b1, 64'h07070707070707FD, 8'hFF};
    vecs[6]  = '{64'hDEADBEEF01234567, 8'h00, 1'b0, IdleD, IdleC};
    vecs[7]  = '{64'h0000000000000000, 8'h00, 1'b0, IdleD, IdleC};
    vecs[8]  = '{64'hA5A5A5A55A5A5A5A, 8'h0F, 1'b0, IdleD, IdleC};
    vecs[9]  = '{64'hD5555555555555FB, 8'h01, 1'b0, IdleD, IdleC};
    vecs[10] = '{64'h123456789ABCDEF0, 8'hF0, 1'b0, IdleD, IdleC};
    vecs[11] = '{64'hFFFFFFFFFFFFFFFF, 8'h80, 1'b0, IdleD, IdleC};

    i_rst         = 1'b0;
    i_soft_rst    = 1'b0;
    i_rst_done    = 1'b1;
    i_block_sync  = 1'b1;
    i_pcs_rx_link = 1'b1;
    i_xgmii_txd   = 64'h0;
    i_xgmii_txc   = 8'h0;

    // Reset values while held in reset.
    #12;
    check_reset_outputs("reset");

    // Bring-up with all status good: 4-cycle PCS reset, then WAIT_DONE (1),
    // WAIT_SYNC (1) and 8 stable cycles before UP.
    @(negedge i_clk);
    i_rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!o_pcs_rst) break;
      cnt++;
      @(negedge i_clk);
    end
    check("bringup pcs_rst width", 64'(cnt), 64'd4);
    cnt = 0;
    while (!o_link_up && cnt < 50) begin
      @(negedge i_clk);
      cnt++;
    end
    check("bringup cycles to link_up", 64'(cnt), 64'd10);

    // Data passes through while UP.
    run_vectors(1'b1);

    // Drop block_sync: UP exit after sync latency, then idles are forced.
    i_block_sync = 1'b0;
`ifdef LINK_CTRL_STAT_EN
    exp_drop++;
`endif
    repeat (4) @(negedge i_clk);
    check("block_sync drop link_up", {63'h0, o_link_up}, 64'h0);
    run_vectors(1'b0);

    // STABLE glitch at count 5 restarts the 8-cycle window.
    i_block_sync = 1'b1;
    cnt = 0;
    while (cnt < 40) begin
      @(negedge i_clk);
      cnt++;
      if (o_link_up) break;
      if (cnt == 6) i_block_sync = 1'b0;
      if (cnt == 7) i_block_sync = 1'b1;
    end
    check("stable glitch cycles to link_up", 64'(cnt), 64'd18);
    check("drop cnt after block_sync drop", {48'h0, o_link_drop_cnt}, 64'(exp_drop));

    // pcs_rx_link drop with data in flight.
    i_xgmii_txd   = 64'hDEADBEEF01234567;
    i_xgmii_txc   = 8'h00;
    i_pcs_rx_link = 1'b0;
    @(negedge i_clk);
    check("rx_link drop data before exit", o_xgmii_txd, 64'hDEADBEEF01234567);
    check("rx_link drop still up", {63'h0, o_link_up}, 64'h1);
    repeat (2) @(negedge i_clk);
    check("rx_link drop link_up", {63'h0, o_link_up}, 64'h0);
    check("rx_link drop last data", o_xgmii_txd, 64'hDEADBEEF01234567);
    @(negedge i_clk);
`ifdef LINK_CTRL_STAT_EN
    exp_drop++;
`endif
    check("rx_link drop idle txd", o_xgmii_txd, IdleD);
    check("rx_link drop idle txc", {56'h0, o_xgmii_txc}, {56'h0, IdleC});
    check("rx_link drop cnt", {48'h0, o_link_drop_cnt}, 64'(exp_drop));
    i_pcs_rx_link = 1'b1;
    wait_up("relink after rx_link", 40);

    // rst_done loss in UP forces RESET.
    i_rst_done = 1'b0;
    repeat (3) @(negedge i_clk);
`ifdef LINK_CTRL_STAT_EN
    exp_drop++;
`endif
    check("rst_done loss pcs_rst", {63'h0, o_pcs_rst}, 64'h1);
    check("rst_done loss link_up", {63'h0, o_link_up}, 64'h0);
    check("rst_done loss drop cnt", {48'h0, o_link_drop_cnt}, 64'(exp_drop));
    i_rst_done = 1'b1;
    wait_up("relink after rst_done", 60);

    // Soft reset in UP: RESET, no retry, not a link drop.
    i_soft_rst = 1'b1;
    @(negedge i_clk);
    i_soft_rst = 1'b0;
    check("soft rst pcs_rst", {63'h0, o_pcs_rst}, 64'h1);
    check("soft rst link_up", {63'h0, o_link_up}, 64'h0);
    check("soft rst drop cnt", {48'h0, o_link_drop_cnt}, 64'(exp_drop));
    check("soft rst retry", {56'h0, o_retry_cnt}, 64'h0);
    wait_up("relink after soft rst", 60);

    // Asynchronous reset while UP takes effect without a clock edge.
    i_xgmii_txd = 64'hA5A5A5A5A5A5A5A5;
    i_xgmii_txc = 8'h00;
    @(negedge i_clk);
    check("async rst pre data", o_xgmii_txd, 64'hA5A5A5A5A5A5A5A5);
    #2;
    i_rst = 1'b0;
    #1;
    check_reset_outputs("async rst");

    // rst_done stuck low for 350 cycles: three retry pulses of 4 cycles.
    i_rst_done = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    rises   = 0;
    width   = 0;
    prev    = 1'b1;
    seen_up = 1'b0;
    for (int i = 0; i <= 350; i++) begin
      if (i > 0) @(negedge i_clk);
      if (o_link_up) seen_up = 1'b1;
      if (o_pcs_rst) begin
        width++;
        if (!prev) rises++;
      end else if (prev) begin
        check($sformatf("timeout pulse width @%0d", i), 64'(width), 64'd4);
        width = 0;
      end
      prev = o_pcs_rst;
    end
    check("timeout retry pulses", 64'(rises), 64'd3);
    check("timeout retry cnt", {56'h0, o_retry_cnt}, 64'd3);
    check("timeout never up", {63'h0, seen_up}, 64'h0);

    // Soft reset coinciding with the WAIT_SYNC timeout at edge 105.
    @(negedge i_clk);
    i_rst        = 1'b0;
    i_rst_done   = 1'b1;
    i_block_sync = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    repeat (104) @(negedge i_clk);
    check("collision pre pcs_rst", {63'h0, o_pcs_rst}, 64'h0);
    i_soft_rst = 1'b1;
    @(negedge i_clk);
    i_soft_rst = 1'b0;
    check("collision pcs_rst", {63'h0, o_pcs_rst}, 64'h1);
    check("collision retry unchanged", {56'h0, o_retry_cnt}, 64'h0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!o_pcs_rst) break;
      cnt++;
      @(negedge i_clk);
    end
    check("collision pcs_rst width", 64'(cnt), 64'd4);
    repeat (101) @(negedge i_clk);
    check("first real timeout retry", {56'h0, o_retry_cnt}, 64'd1);

    // 300 further timeouts: counter saturates at 255.
    dec = 1'b0;
    prev_retry = o_retry_cnt;
    for (int i = 0; i < 300 * 105; i++) begin
      @(negedge i_clk);
      if (o_retry_cnt < prev_retry) dec = 1'b1;
      prev_retry = o_retry_cnt;
    end
    check("retry saturated", {56'h0, o_retry_cnt}, 64'd255);
    check("retry never wrapped", {63'h0, dec}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ten_gig_link_ctrl.md
TEN_GIG_LINK_CTRL -- requirements
Module: ten_gig_link_ctrl

Interface
REQ-001 SHALL have parameter P_RST_CYCLES, default 16: cycles o_pcs_rst is held high per reset attempt.
REQ-002 SHALL have parameter P_TIMEOUT, default 1000000: max cycles spent in WAIT_DONE or WAIT_SYNC before retry.
REQ-003 SHALL have parameter P_STABLE, default 1024: consecutive cycles of good link required before UP.
REQ-004 SHALL have ports: i_clk  in  1  XGMII core clock (156.25 MHz), sole clock.
REQ-005 SHALL have ports: i_rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: i_soft_rst  in  1  one-cycle request to restart bring-up.
REQ-007 SHALL have ports: i_rst_done, i_block_sync, i_pcs_rx_link  in  1 each  PCS/PMA status.
REQ-008 SHALL have ports: i_xgmii_txd  in  64 and i_xgmii_txc  in  8  MAC transmit data and control.
REQ-009 SHALL have ports: o_xgmii_txd  out  64 and o_xgmii_txc  out  8  gated data and control to PCS/PMA.
REQ-010 SHALL have ports: o_pcs_rst  out  1  active-high reset to PCS/PMA; o_link_up  out  1.
REQ-011 SHALL have ports: o_retry_cnt  out  8  timeout retries; o_link_drop_cnt  out  16  UP-exit events.

Function
REQ-012 SHALL pass i_rst_done, i_block_sync and i_pcs_rx_link through 2-flop synchronizers; the FSM uses only synchronized copies.
REQ-013 SHALL implement states RESET, WAIT_DONE, WAIT_SYNC, STABLE, UP; one-hot or binary, implementer's choice.
REQ-014 RESET SHALL assert o_pcs_rst for exactly P_RST_CYCLES cycles, then go to WAIT_DONE.
REQ-015 WAIT_DONE SHALL go to WAIT_SYNC when rst_done=1, or to RESET after P_TIMEOUT cycles.
REQ-016 WAIT_SYNC SHALL go to STABLE when block_sync & pcs_rx_link = 1, or to RESET after P_TIMEOUT cycles.
REQ-017 STABLE SHALL go to UP after P_STABLE consecutive good cycles; any bad cycle SHALL return it to WAIT_SYNC with the count cleared.
REQ-018 UP SHALL go to RESET on rst_done=0; otherwise it SHALL go to WAIT_SYNC on block_sync=0 or pcs_rx_link=0.
REQ-019 In any state, rst_done=0 outside RESET and WAIT_DONE SHALL force RESET.
REQ-020 The timeout counter SHALL clear on every state entry.
REQ-021 A timeout SHALL increment o_retry_cnt, saturating at 255; the count SHALL never wrap.
REQ-022 i_soft_rst SHALL force RESET from any state, including RESET (restarting the count), and SHALL NOT increment o_retry_cnt.
REQ-023 If i_soft_rst and a timeout occur in the same cycle, i_soft_rst SHALL win and o_retry_cnt SHALL be unchanged.
REQ-024 o_link_up SHALL be registered and high only while the state is UP.
REQ-025 o_xgmii_txd/o_xgmii_txc SHALL be registered with 1-cycle latency: the input when state is UP, else 64'h0707070707070707 / 8'hFF.
REQ-026 Gating SHALL take effect on the output cycle after the state enters or leaves UP; truncating a frame mid-frame on link drop is permitted.

Reset
REQ-027 On i_rst=0: state=RESET, counters=0, synchronizers=0, o_pcs_rst=1, o_link_up=0, o_xgmii_txd=64'h0707070707070707, o_xgmii_txc=8'hFF, o_retry_cnt=0, o_link_drop_cnt=0.
REQ-028 After i_rst deassertion, the RESET hold SHALL count P_RST_CYCLES from the first clock edge.

Configuration
REQ-029 With macro LINK_CTRL_STAT_EN defined, o_link_drop_cnt SHALL increment by 1 on each UP exit caused by REQ-018 or REQ-019, saturating at 65535.
REQ-030 Without LINK_CTRL_STAT_EN, o_link_drop_cnt SHALL be constant 0 and its counter logic SHALL be absent; the port SHALL remain.

Verification (P_RST_CYCLES=4, P_TIMEOUT=100, P_STABLE=8)
REQ-031 Status inputs all 1 after reset release -> o_pcs_rst high 4 cycles; o_link_up=1 after 4 + sync latency + 8 stable cycles; idles replaced by input data 1 cycle after UP.
REQ-032 rst_done held 0 for 350 cycles -> 3 RESET pulses of 4 cycles each, o_retry_cnt=3, o_link_up=0.
REQ-033 In STABLE, block_sync dropped for 1 cycle at count 5 -> return to WAIT_SYNC; UP reached only after 8 fresh consecutive good cycles.
REQ-034 In UP, i_xgmii_txd=64'hDEADBEEF_01234567 and pcs_rx_link dropped -> output reverts to 0707.../FF one cycle after UP exit; o_link_drop_cnt=1 (macro defined) or 0 (macro undefined).
REQ-035 i_soft_rst in the same cycle as a WAIT_SYNC timeout -> RESET entered and o_retry_cnt unchanged; 300 forced timeouts -> o_retry_cnt stays 255.
REQ-036 i_rst asserted while in UP -> all outputs take their reset values immediately, without waiting for a clock edge.
